midi_encoder: RTL and testbench

Serializes decoded MIDI messages into the MIDI byte stream for a UART transmitter. It is the transmit-side counterpart of the MIDI decoder: it accepts one `MIDI::message_t` per handshake and emits the status byte and two data bytes, one byte per downstream handshake. It sits between the synth's control/echo logic and the UART TX serializer. Optional running-status compression is supported, with an idle timeout.

---
 rtl/midi_encoder_pkg.sv | 35 +++
 rtl/midi_encoder.sv | 129 ++++++++++++
 tb/tb_midi_encoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/midi_encoder_pkg.sv
// Shared byte-width config and MIDI message types for the transmit path.
// The MIDI package also provides the status byte composition helper.
package CONFIG;
    localparam int BYTE_WIDTH = 8;
endpackage

package MIDI;
    typedef enum logic [3:0] {
        NOTE_OFF         = 4'h8,
        NOTE_ON          = 4'h9,
        POLY_PRESSURE    = 4'hA,
        CONTROL_CHANGE   = 4'hB,
        PROGRAM_CHANGE   = 4'hC,
        CHANNEL_PRESSURE = 4'hD,
        PITCH_BEND       = 4'hE,
        SYSTEM           = 4'hF
    } message_type_t;

    typedef struct packed {
        message_type_t                 message_type;
        logic [CONFIG::BYTE_WIDTH-1:0] data_byte1;
        logic [CONFIG::BYTE_WIDTH-1:0] data_byte2;
    } message_t;

    localparam logic [CONFIG::BYTE_WIDTH-1:0] STATUS_MASK = 8'hF0;
    localparam int CHANNEL_WIDTH = 4;

    // Type nibble in the high half, channel in the low half.
    function automatic logic [CONFIG::BYTE_WIDTH-1:0] status_byte(
        input message_type_t            message_type,
        input logic [CHANNEL_WIDTH-1:0] channel
    );
        return ({message_type, 4'h0} & STATUS_MASK) | {4'h0, channel};
    endfunction
endpackage

// File: rtl/midi_encoder.sv
// Serializes one MIDI message into status + two data bytes for the UART TX,
// with optional running-status compression invalidated after an idle timeout.
module midi_encoder
    import MIDI::*;
#(
    parameter int CHANNEL              = 0,
    parameter bit NOTE_OFF_AS_ZERO_VEL = 1,
    parameter int RS_TIMEOUT           = 15_000_000
) (
    input  logic                          clock_50_000_000,
    input  logic                          reset_l,
    input  message_t                      message,
    input  logic                          message_valid,
    output logic                          message_ready,
    output logic [CONFIG::BYTE_WIDTH-1:0] data_out,
    output logic                          data_out_valid,
    input  logic                          data_out_ready
);
    localparam int BW = CONFIG::BYTE_WIDTH;
    localparam bit RS_EN = (RS_TIMEOUT != 0);
    localparam int TW = RS_EN ? $clog2(RS_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(RS_EN ? RS_TIMEOUT - 1 : 0);
    localparam logic [CHANNEL_WIDTH-1:0] CH = CHANNEL_WIDTH'(CHANNEL);
    localparam logic [BW-1:0] DATA_MASK = {1'b0, {(BW-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, STATUS, DATA1, DATA2} state_t;

    state_t          state, state_n;
    message_t        buffer, buffer_n;
    message_t        mapped;
    logic [BW-1:0]   data_out_n;
    logic            data_out_valid_n;
    logic [BW-1:0]   last_status, last_status_n;
    logic            last_valid, last_valid_n;
    logic [TW-1:0]   timer, timer_n;
    logic [BW-1:0]   new_status, buf_status;
    logic            supported, in_xfer, out_xfer;

    assign message_ready = (state == IDLE);
    assign in_xfer       = message_valid && message_ready;
    assign out_xfer      = data_out_valid && data_out_ready;

    // Buffer holds the already-mapped type and data bytes with bit 7 cleared.
    always_comb begin
        mapped            = message;
        mapped.data_byte1 = message.data_byte1 & DATA_MASK;
        mapped.data_byte2 = message.data_byte2 & DATA_MASK;
        if (NOTE_OFF_AS_ZERO_VEL && message.message_type == NOTE_OFF) begin
            mapped.message_type = NOTE_ON;
            mapped.data_byte2   = '0;
        end
    end

    assign supported  = mapped.message_type inside {NOTE_ON, NOTE_OFF, CONTROL_CHANGE};
    assign new_status = status_byte(mapped.message_type, CH);
    assign buf_status = status_byte(buffer.message_type, CH);

    always_comb begin
        state_n          = state;
        buffer_n         = buffer;
        data_out_n       = data_out;
        data_out_valid_n = data_out_valid;
        last_status_n    = last_status;
        last_valid_n     = last_valid;
        timer_n          = '0;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    buffer_n = mapped;
                    if (supported) begin
                        data_out_valid_n = 1'b1;
                        if (RS_EN && last_valid && new_status == last_status) begin
                            state_n    = DATA1;
                            data_out_n = mapped.data_byte1;
                        end else begin
                            state_n    = STATUS;
                            data_out_n = new_status;
                        end
                    end
                end else if (RS_EN) begin
                    // Saturate at the limit; running status expires here.
                    if (timer == TIMER_MAX) begin
                        last_valid_n = 1'b0;
                        timer_n      = timer;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
            end
            STATUS: if (out_xfer) begin
                state_n    = DATA1;
                data_out_n = buffer.data_byte1;
                if (RS_EN) begin
                    last_status_n = buf_status;
                    last_valid_n  = 1'b1;
                end
            end
            DATA1: if (out_xfer) begin
                state_n    = DATA2;
                data_out_n = buffer.data_byte2;
            end
            DATA2: if (out_xfer) begin
                state_n          = IDLE;
                data_out_valid_n = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state          <= IDLE;
            buffer         <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            last_status    <= '0;
            last_valid     <= 1'b0;
            timer          <= '0;
        end else begin
            state          <= state_n;
            buffer         <= buffer_n;
            data_out       <= data_out_n;
            data_out_valid <= data_out_valid_n;
            last_status    <= last_status_n;
            last_valid     <= last_valid_n;
            timer          <= timer_n;
        end
    end
endmodule

// File: tb/tb_midi_encoder.sv
// Scoreboard bench: dut_a has running status off (channel 0, raw NOTE_OFF),
// dut_b has running status with an 8-cycle timeout (channel 3, NOTE_OFF as vel 0).
module tb_midi_encoder;
    import MIDI::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    message_t    msg [2];
    logic        mv [2];
    logic        mr [2];
    logic        dv [2];
    logic        rdy [2];
    logic [7:0]  dout [2];
    logic [7:0]  exp_q0 [$];
    logic [7:0]  exp_q1 [$];
    logic        stalled [2];
    logic [7:0]  held [2];
    logic        stall_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    midi_encoder #(.CHANNEL(0), .NOTE_OFF_AS_ZERO_VEL(0), .RS_TIMEOUT(0)) dut_a (
        .clock_50_000_000(clk), .reset_l(rst_n),
        .message(msg[0]), .message_valid(mv[0]), .message_ready(mr[0]),
        .data_out(dout[0]), .data_out_valid(dv[0]), .data_out_ready(rdy[0]));

    midi_encoder #(.CHANNEL(3), .NOTE_OFF_AS_ZERO_VEL(1), .RS_TIMEOUT(8)) dut_b (
        .clock_50_000_000(clk), .reset_l(rst_n),
        .message(msg[1]), .message_valid(mv[1]), .message_ready(mr[1]),
        .data_out(dout[1]), .data_out_valid(dv[1]), .data_out_ready(rdy[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    task automatic send(input int d, input logic [3:0] t, input logic [7:0] b1, input logic [7:0] b2);
        int n = 0;
        @(negedge clk);
        msg[d].message_type = message_type_t'(t);
        msg[d].data_byte1   = b1;
        msg[d].data_byte2   = b2;
        mv[d] = 1'b1;
        while (!mr[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_dut%0d", d), mr[d], 1);
        @(posedge clk);
        #1 mv[d] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);
    endtask

    // Random downstream back-pressure.
    initial forever begin
        @(posedge clk);
        #1;
        if (stall_en)
            for (int d = 0; d < 2; d++) rdy[d] = ($urandom_range(0, 1) == 0);
    end

    // Monitor: pop expected bytes on each output transfer, check hold while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled[0] = 1'b0;
            stalled[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (stalled[d]) begin
                    check($sformatf("hold_valid_dut%0d", d), dv[d], 1);
                    check($sformatf("hold_data_dut%0d", d), dout[d], held[d]);
                end
                if (dv[d] && rdy[d]) begin
                    if ((d == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte_dut%0d: got 0x%0h expected none", d, dout[d]);
                    end else if (d == 0) begin
                        check("byte_dut0", dout[0], exp_q0.pop_front());
                    end else begin
                        check("byte_dut1", dout[1], exp_q1.pop_front());
                    end
                end
                stalled[d] = dv[d] && !rdy[d];
                held[d]    = dout[d];
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            mv[d]  = 1'b0;
            rdy[d] = 1'b1;
            msg[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready_dut%0d", d), mr[d], 1);
            check($sformatf("rst_valid_dut%0d", d), dv[d], 0);
            check($sformatf("rst_data_dut%0d", d), dout[d], 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // dut_a: no running status, every message carries its status byte
        push(0, 8'h90); push(0, 8'h3C); push(0, 8'h64);
        send(0, 4'h9, 8'd60, 8'd100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_ready_dut0", mr[0], (i == 3));
        end
        push(0, 8'h90); push(0, 8'h3C); push(0, 8'h64);
        send(0, 4'h9, 8'd60, 8'd100);
        push(0, 8'h80); push(0, 8'h3C); push(0, 8'h40);
        send(0, 4'h8, 8'd60, 8'd64);
        push(0, 8'hB0); push(0, 8'h07); push(0, 8'h7F);
        send(0, 4'hB, 8'd7, 8'd127);
        send(0, 4'hE, 8'h12, 8'h34);
        @(negedge clk);
        check("unsup_ready_dut0", mr[0], 1);
        check("unsup_valid_dut0", dv[0], 0);
        push(0, 8'h90); push(0, 8'h3C); push(0, 8'h64);
        send(0, 4'h9, 8'hBC, 8'hE4);

        // dut_b: running status and idle timeout
        push(1, 8'h93); push(1, 8'h3C); push(1, 8'h64);
        send(1, 4'h9, 8'd60, 8'd100);
        push(1, 8'h3C); push(1, 8'h00);
        send(1, 4'h8, 8'd60, 8'd55);
        repeat (14) @(negedge clk);
        push(1, 8'h93); push(1, 8'h3C); push(1, 8'h64);
        send(1, 4'h9, 8'd60, 8'd100);
        repeat (6) @(negedge clk);
        push(1, 8'h3E); push(1, 8'h0A);
        send(1, 4'h9, 8'd62, 8'd10);
        push(1, 8'hB3); push(1, 8'h07); push(1, 8'h7F);
        send(1, 4'hB, 8'd7, 8'd127);
        push(1, 8'h93); push(1, 8'h3C); push(1, 8'h01);
        send(1, 4'h9, 8'd60, 8'd1);
        send(1, 4'hE, 8'h00, 8'h40);
        @(negedge clk);
        check("unsup_ready_dut1", mr[1], 1);
        check("unsup_valid_dut1", dv[1], 0);
        push(1, 8'h40); push(1, 8'h50);
        send(1, 4'h9, 8'd64, 8'd80);
        drain();

        // Random back-pressure
        stall_en = 1'b1;
        push(0, 8'h90); push(0, 8'h10); push(0, 8'h20);
        send(0, 4'h9, 8'h10, 8'h20);
        push(0, 8'hB0); push(0, 8'h11); push(0, 8'h22);
        send(0, 4'hB, 8'h11, 8'h22);
        push(1, 8'hB3); push(1, 8'h01); push(1, 8'h02);
        send(1, 4'hB, 8'h01, 8'h02);
        push(1, 8'h93); push(1, 8'h05); push(1, 8'h06);
        send(1, 4'h9, 8'h05, 8'h06);
        push(1, 8'h05); push(1, 8'h00);
        send(1, 4'h8, 8'h05, 8'h09);
        drain();
        stall_en = 1'b0;
        @(posedge clk);
        #1;
        rdy[0] = 1'b1;
        rdy[1] = 1'b0;

        // Reset while a running-status data byte is pending
        send(1, 4'h9, 8'd60, 8'd100);
        repeat (2) @(negedge clk);
        check("pend_valid_dut1", dv[1], 1);
        check("pend_data_dut1", dout[1], 8'h3C);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready_dut1", mr[1], 1);
        check("mid_rst_valid_dut1", dv[1], 0);
        check("mid_rst_data_dut1", dout[1], 0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rdy[1] = 1'b1;
        push(1, 8'h93); push(1, 8'h3C); push(1, 8'h64);
        send(1, 4'h9, 8'd60, 8'd100);
        drain();
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
